// File: rtl/div_unit_pkg.sv
// Shared constants, state encodings and payload types for the radix-2 restoring divider.
package div_unit_pkg;

    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned COUNT_WIDTH  = 6;
    localparam int unsigned RESULT_WIDTH = 2 * DATA_WIDTH;
    localparam int unsigned WORK_WIDTH   = 2 * DATA_WIDTH + 1;

    localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;

    localparam logic [1:0] DIV_FREE    = 2'b00;
    localparam logic [1:0] DIV_BY_ZERO = 2'b01;
    localparam logic [1:0] DIV_ON      = 2'b10;
    localparam logic [1:0] DIV_END     = 2'b11;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    // HI/LO payload: remainder in the upper word, quotient in the lower word
    typedef struct packed {
        logic [DATA_WIDTH-1:0] rem;
        logic [DATA_WIDTH-1:0] quot;
    } div_result_t;

    function automatic logic [DATA_WIDTH-1:0] cond_negate(input logic [DATA_WIDTH-1:0] x,
                                                          input logic                  en);
        return en ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface div_unit_if;
    import div_unit_pkg::*;

    logic                  signed_div_input;
    logic [DATA_WIDTH-1:0] opdata1_input;
    logic [DATA_WIDTH-1:0] opdata2_input;
    logic                  start_input;
    logic                  annul_input;
    div_result_t           result_output;
    logic                  ready_output;

    modport master (
        output signed_div_input, opdata1_input, opdata2_input, start_input, annul_input,
        input  result_output, ready_output
    );

    modport slave (
        input  signed_div_input, opdata1_input, opdata2_input, start_input, annul_input,
        output result_output, ready_output
    );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU; result {remainder, quotient}
// appears 33 edges after the request is accepted and is held while start stays high.
module div_unit
    import div_unit_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    div_unit_if.slave bus
);

    logic [1:0]             state,       state_n;
    logic [COUNT_WIDTH-1:0] counter,     counter_n;
    logic [WORK_WIDTH-1:0]  work,        work_n;
    logic [DATA_WIDTH-1:0]  divisor_abs, divisor_abs_n;
    logic                   neg_quot,    neg_quot_n;
    logic                   neg_rem,     neg_rem_n;
    div_result_t            result,      result_n;
    logic                   ready,       ready_n;

    logic [DATA_WIDTH:0]    diff;
    logic [WORK_WIDTH-1:0]  work_step;
    logic                   accept;

    assign bus.result_output = result;
    assign bus.ready_output  = ready;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= DIV_FREE;
            counter     <= '0;
            work        <= '0;
            divisor_abs <= '0;
            neg_quot    <= 1'b0;
            neg_rem     <= 1'b0;
            result      <= '{rem: ZERO_WORD, quot: ZERO_WORD};
            ready       <= DIV_RESULT_NOT_READY;
        end else begin
            state       <= state_n;
            counter     <= counter_n;
            work        <= work_n;
            divisor_abs <= divisor_abs_n;
            neg_quot    <= neg_quot_n;
            neg_rem     <= neg_rem_n;
            result      <= result_n;
            ready       <= ready_n;
        end
    end

    // Next-state, one restoring step, and registered-output values
    always_comb begin
        state_n       = state;
        counter_n     = counter;
        work_n        = work;
        divisor_abs_n = divisor_abs;
        neg_quot_n    = neg_quot;
        neg_rem_n     = neg_rem;
        result_n      = result;
        ready_n       = ready;

        accept = (bus.start_input == DIV_START) && !bus.annul_input;
        diff   = {1'b0, work[2*DATA_WIDTH-1:DATA_WIDTH]} - {1'b0, divisor_abs};
        work_step = diff[DATA_WIDTH] ? {work[2*DATA_WIDTH-1:0], 1'b0}
                                     : {diff[DATA_WIDTH-1:0], work[DATA_WIDTH-1:0], 1'b1};

        case (state)
            DIV_FREE: begin
                result_n = '{rem: ZERO_WORD, quot: ZERO_WORD};
                ready_n  = DIV_RESULT_NOT_READY;
                if (accept) begin
                    neg_quot_n    = bus.signed_div_input &
                                    (bus.opdata1_input[DATA_WIDTH-1] ^ bus.opdata2_input[DATA_WIDTH-1]);
                    neg_rem_n     = bus.signed_div_input & bus.opdata1_input[DATA_WIDTH-1];
                    divisor_abs_n = cond_negate(bus.opdata2_input,
                                                bus.signed_div_input & bus.opdata2_input[DATA_WIDTH-1]);
                    work_n        = {ZERO_WORD,
                                     cond_negate(bus.opdata1_input,
                                                 bus.signed_div_input & bus.opdata1_input[DATA_WIDTH-1]),
                                     1'b0};
                    counter_n     = '0;
                    state_n       = (bus.opdata2_input == ZERO_WORD) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                result_n = '{rem: ZERO_WORD, quot: ZERO_WORD};
                if (bus.annul_input) begin
                    state_n = DIV_FREE;
                    ready_n = DIV_RESULT_NOT_READY;
                end else begin
                    state_n = DIV_END;
                    ready_n = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (bus.annul_input) begin
                    state_n   = DIV_FREE;
                    counter_n = '0;
                    ready_n   = DIV_RESULT_NOT_READY;
                    result_n  = '{rem: ZERO_WORD, quot: ZERO_WORD};
                end else begin
                    work_n    = work_step;
                    counter_n = counter + 1'b1;
                    // Final iteration folds the sign fix-up into the same edge
                    if (counter == COUNT_WIDTH'(DATA_WIDTH - 1)) begin
                        state_n       = DIV_END;
                        ready_n       = DIV_RESULT_READY;
                        result_n.quot = cond_negate(work_step[DATA_WIDTH-1:0], neg_quot);
                        result_n.rem  = cond_negate(work_step[WORK_WIDTH-1:DATA_WIDTH+1], neg_rem);
                    end
                end
            end
            DIV_END: begin
                if ((bus.start_input == DIV_STOP) || bus.annul_input) begin
                    state_n   = DIV_FREE;
                    counter_n = '0;
                    ready_n   = DIV_RESULT_NOT_READY;
                    result_n  = '{rem: ZERO_WORD, quot: ZERO_WORD};
                end
            end
            default: begin
                state_n = DIV_FREE;
                ready_n = DIV_RESULT_NOT_READY;
            end
        endcase
    end

endmodule
